// File: rtl/slide_pkg.sv
// slide_pkg
//   Types and constants shared between the move conditioner and the tile
//   engine.
//   dir_t      : direction code carried on the move handshake
//   PRIO_ORDER : press arbitration order, highest priority first
//   pick_dir   : highest-priority direction present in a press vector
package slide_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'b00,
        RIGHT = 2'b01,
        UP    = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    localparam int NUM_DIRS = 4;

    // Vertical moves win over horizontal ones when presses coincide.
    localparam dir_t PRIO_ORDER [NUM_DIRS] = '{UP, DOWN, LEFT, RIGHT};

    // Scan from lowest to highest priority so the last hit is the winner.
    // Press vectors are indexed by direction code.
    function automatic dir_t pick_dir(input logic [NUM_DIRS-1:0] ev);
        dir_t sel;
        sel = PRIO_ORDER[NUM_DIRS-1];
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (ev[PRIO_ORDER[i]]) sel = PRIO_ORDER[i];
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchroniser plus a stability counter for one raw push-button.
//   A level change of the synchronised input is accepted only after it has
//   held for DEBOUNCE_CYCLES consecutive cycles.
//   clk, reset : clock, synchronous active-high reset
//   btn        : raw asynchronous button, active-high
//   press      : combinational, high in the cycle whose closing edge flips
//                the debounced level 0->1 (one pulse per press)
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          settle;

    // Synchronised level has disagreed with the accepted level long enough.
    assign settle = (s2 != stable) && (cnt == CNT_LAST);
    // Only rising acceptances are presses; releases are silent.
    assign press  = settle && s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == stable) begin
                // Any return to the accepted level restarts the window.
                cnt <= '0;
            end else if (settle) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/slide_move_input.sv
// slide_move_input
//   Move conditioner in front of the 3x3 sliding-tile engine. Debounces four
//   direction buttons, arbitrates simultaneous presses, buffers tokens in a
//   small FIFO and offers them on a valid/ready handshake.
//   clk, reset                          : clock, synchronous active-high reset
//   btn_left/right/up/down              : raw buttons, active-high
//   dir, dir_valid, dir_ready           : head token handshake
//   move_count                          : completed transfers, saturating
//   overflow                            : sticky, a press hit a full FIFO
module slide_move_input
    import slide_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] dir,
    output logic       dir_valid,
    input  logic       dir_ready,
    output logic [7:0] move_count,
    output logic       overflow
);

    localparam int           PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]  DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    // Button vectors are indexed by direction code.
    logic [NUM_DIRS-1:0] btn_raw;
    logic [NUM_DIRS-1:0] press;
    logic                any_press;
    dir_t                push_dir;

    assign btn_raw = {btn_down, btn_up, btn_right, btn_left};

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db [NUM_DIRS-1:0] (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_raw),
        .press(press)
    );

    // Losing simultaneous presses are dropped without flagging overflow.
    assign any_press = |press;
    assign push_dir  = pick_dir(press);

    // ---------------- token FIFO ----------------
    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count == DEPTH_C);
    assign dir_valid = (count != '0);
    assign dir       = mem[rptr];
    assign pop       = dir_valid && dir_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = any_press && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            move_count <= '0;
            // Cleared so dir reads 00 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 2'b00;
        end else begin
            if (push) begin
                mem[wptr] <= push_dir;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (any_press && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && (move_count != 8'hFF)) begin
                move_count <= move_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slide_move_input.sv
// tb_slide_move_input
//   Scoreboard bench: expected tokens are queued as presses are driven and
//   compared in order against every completed transfer.
module tb_slide_move_input;
    import slide_pkg::*;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_up, btn_down;
    logic [1:0] dir;
    logic       dir_valid;
    logic       dir_ready;
    logic [7:0] move_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q [$];

    slide_move_input #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .dir       (dir),
        .dir_valid (dir_valid),
        .dir_ready (dir_ready),
        .move_count(move_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then step just past the edge to drive.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transfer monitor: every accepted token must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && dir_valid && dir_ready) begin
            if (exp_q.size() == 0) chk("unexpected_xfer", 1, 0);
            else                   chk("xfer_dir", int'(dir), int'(exp_q.pop_front()));
        end
    end

    // Drive one press of width hi, then hold low for lo cycles.
    task automatic press_btn(input dir_t d, input int hi, input int lo);
        case (d)
            LEFT:  btn_left  = 1'b1;
            RIGHT: btn_right = 1'b1;
            UP:    btn_up    = 1'b1;
            DOWN:  btn_down  = 1'b1;
        endcase
        tick(hi);
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(lo);
    endtask

    // Watch n cycles after the current drive point; report first cycle
    // with dir_valid high (0 if none) and how many cycles it was high.
    task automatic watch(input int n, output int first, output int nvalid);
        first  = 0;
        nvalid = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dir_valid) begin
                nvalid++;
                if (first == 0) first = c;
            end
        end
        #1;
    endtask

    int first, nvalid;

    initial begin
        reset = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        dir_ready = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_dir", int'(dir), 0);
        chk("rst_valid", int'(dir_valid), 0);
        chk("rst_count", int'(move_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Single press: one token at cycle DB+2, consumed immediately.
        dir_ready = 1'b1;
        btn_up = 1'b1;
        exp_q.push_back(UP);
        watch(40, first, nvalid);
        chk("single_first", first, DB + 2);
        chk("single_nvalid", nvalid, 1);
        btn_up = 1'b0;
        tick(25);
        chk("single_count", int'(move_count), 1);

        // Glitches shorter than the debounce window never make a token.
        fork
            repeat (5) press_btn(RIGHT, 10, 3);
            watch(90, first, nvalid);
        join
        chk("glitch_nvalid", nvalid, 0);
        chk("glitch_count", int'(move_count), 1);

        // Simultaneous LEFT and DOWN: DOWN wins, LEFT is lost silently.
        btn_left = 1'b1;
        btn_down = 1'b1;
        exp_q.push_back(DOWN);
        watch(40, first, nvalid);
        chk("simul_nvalid", nvalid, 1);
        btn_left = 1'b0;
        btn_down = 1'b0;
        tick(25);
        chk("simul_count", int'(move_count), 2);
        chk("simul_ovf", int'(overflow), 0);

        // Backpressure: five presses into a 4-deep FIFO, fifth overflows.
        dir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(LEFT);
            press_btn(LEFT, 20, 20);
        end
        @(negedge clk);
        chk("bp_valid", int'(dir_valid), 1);
        chk("bp_head", int'(dir), int'(LEFT));
        chk("bp_ovf", int'(overflow), 1);
        chk("bp_count_held", int'(move_count), 2);
        tick(1);
        dir_ready = 1'b1;
        tick(10);
        chk("bp_drain_count", int'(move_count), 6);
        chk("bp_drain_ovf", int'(overflow), 1);
        chk("bp_drain_valid", int'(dir_valid), 0);
        chk("bp_sb_empty", exp_q.size(), 0);

        // Clear overflow before the concurrent-pop case.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst2_count", int'(move_count), 0);
        chk("rst2_ovf", int'(overflow), 0);

        // Full FIFO with a pop on the same edge as the push.
        dir_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(UP);
            press_btn(UP, 20, 20);
        end
        btn_right = 1'b1;
        exp_q.push_back(RIGHT);
        tick(DB + 1);
        dir_ready = 1'b1;
        tick(1);
        dir_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_ovf", int'(overflow), 0);
        chk("fullpop_count", int'(move_count), 1);
        chk("fullpop_head", int'(dir), int'(UP));
        tick(1);
        btn_right = 1'b0;
        dir_ready = 1'b1;
        tick(10);
        chk("fullpop_drain", int'(move_count), 5);
        chk("fullpop_sb_empty", exp_q.size(), 0);
        dir_ready = 1'b0;
        tick(25);

        // Reset mid-operation with DOWN held throughout.
        for (int i = 0; i < 3; i++) press_btn(LEFT, 20, 20);
        chk("mid_valid_pre", int'(dir_valid), 1);
        btn_down = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(DOWN);
        dir_ready = 1'b1;
        chk("mid_count_rst", int'(move_count), 0);
        watch(40, first, nvalid);
        chk("mid_first", first, DB + 2);
        chk("mid_nvalid", nvalid, 1);
        chk("mid_count", int'(move_count), 1);
        chk("mid_ovf", int'(overflow), 0);
        chk("mid_sb_empty", exp_q.size(), 0);
        btn_down = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slide_move_input.md
# slide_move_input

Front-end move conditioner for the 3x3 sliding-tile game. It synchronises and debounces four raw direction buttons and converts each clean press into a single direction token. Tokens are buffered in a small FIFO and presented to the tile engine through a valid/ready handshake. It sits directly upstream of the tile engine, which consumes one `dir` code per accepted transfer.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required to accept a level change; legal range 2..255.
- `FIFO_DEPTH`, default 4: token buffer entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`  in  1 each  raw asynchronous push-buttons, active-high.
- `dir`  out  2  direction code: LEFT=00, RIGHT=01, UP=10, DOWN=11.
- `dir_valid`  out  1  FIFO non-empty; `dir` holds the head token.
- `dir_ready`  in  1  downstream accepts the head token this cycle.
- `move_count`  out  8  number of completed transfers (`dir_valid & dir_ready`), saturating at 255.
- `overflow`  out  1  sticky; a press was dropped because the FIFO was full.

## Operation
- **Per-button path**
  - Two-flop synchroniser (`s1`, `s2`).
  - Debounced `stable` bit and a counter of width clog2(`DEBOUNCE_CYCLES`).
- **Debounce**
  - While `s2 == stable`, the counter is 0.
  - While `s2 != stable`, the counter increments each edge.
  - At the edge where `s2 != stable` and the counter is `DEBOUNCE_CYCLES-1`, `stable <= s2` and the counter clears.
  - Any return of `s2` to `stable` clears the counter, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- **Press event**
  - Asserted combinationally on the edge where `stable` flips 0→1.
  - Releases (1→0) generate nothing.
  - A held button generates exactly one press.
- **Arbitration**
  - If several press events occur on the same edge, only the highest priority is enqueued: UP > DOWN > LEFT > RIGHT.
  - The others are discarded silently; `overflow` is not set.
- **FIFO**
  - Circular buffer with read/write pointers plus a count.
  - Push: press event && (not full || pop this cycle).
  - Pop: `dir_valid & dir_ready`.
  - Simultaneous push and pop when full: both occur, and count is unchanged.
  - Push when empty: the token appears on `dir` the next cycle. There is no bypass; the output is always registered.
  - Press while full with no pop: token dropped, `overflow <= 1` (held until reset).
- **Handshake**
  - `dir` is the head entry and stays stable while `dir_valid && !dir_ready`.
  - `dir_ready` while `!dir_valid` has no effect.
  - `dir_valid` does not depend combinationally on `dir_ready`.
- **move_count**: +1 per transfer; holds at 255.
- **Move legality**: this block does not filter illegal moves. The tile engine ignores moves that would leave the board.

## Timing
- **Reset values**: all synchronisers, `stable`, counters and pointers 0; `dir=00`, `dir_valid=0`, `move_count=0`, `overflow=0`.
- **Press latency**: button high before edge 1 and held → `s2` high after edge 2 → press at edge `DEBOUNCE_CYCLES+2` → `dir_valid=1` in cycle `DEBOUNCE_CYCLES+2` (cycle 18 at default).
- **Throughput**: one push and one pop per cycle.
- **Reset mid-operation**: FIFO flushed and debounce state cleared. A button still held when reset deasserts produces a fresh press, `DEBOUNCE_CYCLES+2` cycles later.
- **Release before re-press**: after release the button must be low for `DEBOUNCE_CYCLES` synchronised cycles before a re-press registers.

## Structure
- Shared package `slide_pkg`:
  - `dir_t` enum (LEFT, RIGHT, UP, DOWN with the codes above); the tile engine imports the same type.
  - Priority-order constant.
- Sub-module `btn_debounce` (synchroniser, counter, `stable`, press pulse), parameterised by `DEBOUNCE_CYCLES` and instantiated four times.
- FIFO is inline in `slide_move_input`.

## Test plan
- **Single press**: UP held 40 cycles, `dir_ready=1` → `dir_valid` is high for exactly 1 cycle (cycle 18), `dir=10`, `move_count=1`.
- **Glitch**: RIGHT pulses of 10 cycles, gaps of 3 → no token, `dir_valid` stays 0.
- **Simultaneous**: LEFT and DOWN raised on the same cycle and held → exactly one token, `dir=11`; LEFT is lost.
- **Backpressure/overflow**: `dir_ready=0`; five separate LEFT presses → 4 tokens `00` are queued, `overflow=1`. Then `dir_ready=1` → 4 transfers, `move_count=4`, `overflow` still 1.
- **Full with concurrent pop**: FIFO full; a press arrives on the same cycle `dir_ready=1` → token accepted, count stays 4, `overflow` stays 0.
- **Reset mid-operation**: 3 tokens queued, DOWN held through a 2-cycle reset → after reset `dir_valid=0` until a single `11` token appears 18 cycles after deassert; `move_count=0`.
